// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generator: address type, reset vector and command/state enums.
package Types;
  typedef logic [31:0] addr_t;
endpackage

package Parameters;
  localparam Types::addr_t InstStartFromActual = 32'h0000_1000;
endpackage

package PCType;
  typedef enum logic [2:0] {
    HOLD        = 3'd0,
    INC         = 3'd1,
    INC_OFFSET  = 3'd2,
    LOAD        = 3'd3,
    CALL_OFFSET = 3'd4,
    CALL_LOAD   = 3'd5,
    RET         = 3'd6
  } pc_cmd_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_t;
endpackage

// File: rtl/pc_gen_if.sv
// Command/redirect inputs and fetch-side outputs of the PC generator.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();
  PCType::pc_cmd_t   cmd;
  logic [XLEN-1:0]   operand;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_vec;
  logic              fetch_ready;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   inc_pc;
  logic              fetch_valid;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_miss;
  logic              misaligned;

  modport master (
    output cmd, operand, trap_valid, trap_vec, fetch_ready,
    input  pc, inc_pc, fetch_valid, ras_empty, ras_full, ras_miss, misaligned
  );

  modport slave (
    input  cmd, operand, trap_valid, trap_vec, fetch_ready,
    output pc, inc_pc, fetch_valid, ras_empty, ras_full, ras_miss, misaligned
  );
endinterface

// File: rtl/pc_gen_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    sp_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign top   = mem[sp_q - PW'(1)];

  // sp_q points at the next free slot; wrapping lets a full push overwrite the oldest
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + PW'(1);
      if (!full) count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      sp_q    <= sp_q - PW'(1);
      count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp_q] <= push_data;
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/branch/call/return next-PC selection with trap redirect.
module pc_gen
  import PCType::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(Parameters::InstStartFromActual)
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inc_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic            fire, push, pop, miss_d;
  logic            ras_miss_q, misaligned_q;

  assign inc_pc          = pc_q + XLEN'(4);
  assign fire            = (state_q == RUN) && bus.fetch_ready;
  assign bus.pc          = pc_q;
  assign bus.inc_pc      = inc_pc;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.ras_empty   = ras_empty;
  assign bus.ras_full    = ras_full;
  assign bus.ras_miss    = ras_miss_q;
  assign bus.misaligned  = misaligned_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
    if (bus.trap_valid) state_d = BUBBLE;
  end

  // Next-PC selection; RAS side effects only when the command is actually accepted
  always_comb begin
    target = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    miss_d = 1'b0;
    case (bus.cmd)
      INC:         target = inc_pc;
      INC_OFFSET:  target = inc_pc + bus.operand;
      LOAD:        target = bus.operand;
      CALL_OFFSET: begin target = inc_pc + bus.operand; push = 1'b1; end
      CALL_LOAD:   begin target = bus.operand;          push = 1'b1; end
      RET: begin
        if (ras_empty) begin
          target = bus.operand;
          miss_d = 1'b1;
        end else begin
          target = ras_top;
          pop    = 1'b1;
        end
      end
      default:     target = pc_q;
    endcase
    if (!fire || bus.trap_valid) begin
      push   = 1'b0;
      pop    = 1'b0;
      miss_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ras_miss_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      ras_miss_q   <= miss_d;
      misaligned_q <= 1'b0;
      if (bus.trap_valid) begin
        pc_q <= {bus.trap_vec[XLEN-1:2], 2'b00};
      end else if (fire) begin
        pc_q         <= {target[XLEN-1:2], 2'b00};
        misaligned_q <= (target[1:0] != 2'b00);
      end
    end
  end

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (inc_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
endmodule
